tm1638_led_driver: RTL and testbench

TM1638_LED_DRIVER -- requirements
Module: tm1638_led_driver

---
 rtl/tm1638_led_driver.sv | 164 ++++++++++++++++
 tb/tb_tm1638_led_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_led_driver.sv
// TM1638 LED driver: snapshots an 8-bit LED pattern and streams it to the TM1638 as one frame
// (mode command, address + 16 data bytes, display-control command) whenever the pattern changes.
module tm1638_led_driver #(
  parameter int         CLK_DIV    = 25,
  parameter logic [2:0] BRIGHTNESS = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] led,
  output logic       tm_stb,
  output logic       tm_clk,
  output logic       tm_dio,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW       = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BIT_LO, BIT_HI, END, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [4:0]    byte_q, byte_d;
  logic [1:0]    txn_q, txn_d;
  logic          dio_q, dio_d;
  logic [7:0]    snap_q, snap_d;
  logic [7:0]    last_q, last_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;
  logic [7:0]    nxt_byte;

  // Odd grid bytes carry one LED each in bit 0; even bytes are the blank 7-segment digits.
  function automatic logic [7:0] byte_val(input logic [1:0] txn, input logic [4:0] idx,
                                          input logic [7:0] s);
    logic [3:0] k;
    byte_val = 8'h00;
    k        = idx[3:0] - 4'd1;
    case (txn)
      2'd0:    byte_val = 8'h40;
      2'd1: begin
        if (idx == 5'd0)  byte_val = 8'hC0;
        else if (k[0])    byte_val = {7'b0, s[k[3:1]]};
      end
      default: byte_val = 8'h88 | {5'b0, BRIGHTNESS};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      txn_q     <= '0;
      dio_q     <= 1'b1;
      snap_q    <= '0;
      last_q    <= '0;
      pending_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      txn_q     <= txn_d;
      dio_q     <= dio_d;
      snap_q    <= snap_d;
      last_q    <= last_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    txn_d     = txn_q;
    dio_d     = dio_q;
    snap_d    = snap_q;
    last_d    = last_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    nxt_byte  = 8'h00;

    case (state_q)
      IDLE: begin
        if (pending_q || (led != last_q)) begin
          state_d   = START;
          snap_d    = led;
          pending_d = 1'b0;
          cnt_d     = '0;
          bit_d     = '0;
          byte_d    = '0;
          txn_d     = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = BIT_LO;
        end
      end
      BIT_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = BIT_HI;
        end
      end
      BIT_HI: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = BIT_LO;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            if (txn_q != 2'd1 || byte_q == 5'd16) state_d = END;
            else                                  byte_d  = byte_q + 1'b1;
          end
        end
      end
      END: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_END) begin
          cnt_d  = '0;
          byte_d = '0;
          if (txn_q == 2'd2) begin
            state_d = IDLE;
            done_d  = 1'b1;
            last_d  = snap_q;
          end else begin
            state_d = START;
            txn_d   = txn_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // DIO only moves on entry to a low phase, so it is stable across every high phase.
    nxt_byte = byte_val(txn_d, byte_d, snap_d);
    if (state_d == BIT_LO && state_q != BIT_LO) dio_d = nxt_byte[bit_d];
  end

  assign tm_stb     = (state_q == IDLE) || (state_q == GAP);
  assign tm_clk     = (state_q != BIT_LO);
  assign tm_dio     = dio_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_tm1638_led_driver.sv
// Directed bench for tm1638_led_driver: decodes the TM1638 pins back into bytes and checks
// frames, timing, mid-frame pattern changes and asynchronous reset.
module tb_tm1638_led_driver;

  logic       clk = 1'b0;
  logic       reset1 = 1'b1;
  logic [7:0] led1 = 8'h00;
  logic       stb1, sclk1, dio1, busy1, done1;

  logic       reset2 = 1'b1;
  logic [7:0] led2 = 8'hA5;
  logic       stb2, sclk2, dio2, busy2, done2;

  int tests_run    = 0;
  int tests_failed = 0;

  tm1638_led_driver #(.CLK_DIV(25), .BRIGHTNESS(3'd7)) dut (
    .clk(clk), .reset(reset1), .led(led1), .tm_stb(stb1), .tm_clk(sclk1),
    .tm_dio(dio1), .busy(busy1), .frame_done(done1)
  );

  tm1638_led_driver #(.CLK_DIV(1), .BRIGHTNESS(3'd2)) dut_fast (
    .clk(clk), .reset(reset2), .led(led2), .tm_stb(stb2), .tm_clk(sclk2),
    .tm_dio(dio2), .busy(busy2), .frame_done(done2)
  );

  always #5 clk = ~clk;

  // Pin decoder: one byte per 8 rising tm_clk edges while STB is low.
  logic [1:0] m_stb, m_clk, m_dio;
  assign m_stb = {stb2, sclk2 & 1'b0 | stb2 & 1'b1} ;
  assign m_clk = {sclk2, sclk1};
  assign m_dio = {dio2, dio1};

  logic       prev_stb[2] = '{1'b1, 1'b1};
  logic       prev_clk[2] = '{1'b1, 1'b1};
  logic       prev_dio[2] = '{1'b1, 1'b1};
  logic [7:0] sh[2];
  int         nbits[2]    = '{0, 0};
  int         tlen[2]     = '{0, 0};
  int         stab_err[2] = '{0, 0};
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  int         txl0[$];
  int         txl1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic s;
      s = (i == 0) ? stb1 : stb2;
      if (!s && prev_stb[i]) begin
        nbits[i] = 0;
        tlen[i]  = 0;
      end
      if (!s && m_clk[i] && !prev_clk[i]) begin
        sh[i] = {m_dio[i], sh[i][7:1]};
        nbits[i]++;
        if (nbits[i] == 8) begin
          nbits[i] = 0;
          tlen[i]++;
          if (i == 0) cap0.push_back(sh[i]);
          else        cap1.push_back(sh[i]);
        end
      end
      if (s && !prev_stb[i]) begin
        if (i == 0) txl0.push_back(tlen[i]);
        else        txl1.push_back(tlen[i]);
      end
      if (m_clk[i] && prev_clk[i] && (m_dio[i] != prev_dio[i])) stab_err[i]++;
      prev_stb[i] = s;
      prev_clk[i] = m_clk[i];
      prev_dio[i] = m_dio[i];
    end
  end

  // Expected byte idx (0..18) of a whole frame: 40, C0, 16 grid bytes, 88|brightness.
  function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] s, input logic [2:0] br);
    int k;
    if (idx == 0)  return 8'h40;
    if (idx == 1)  return 8'hC0;
    if (idx == 18) return 8'h88 | {5'b0, br};
    k = idx - 2;
    if (k % 2 == 1) return {7'b0, s[(k - 1) / 2]};
    return 8'h00;
  endfunction

  // Counts busy samples from the next negedge until frame_done, within a cycle budget.
  task automatic wait_frame(input bit which, input int budget, output int nbusy,
                            output bit seen, output bit busy_at_done,
                            output bit first_busy, output bit first_stb);
    nbusy = 0; seen = 0; busy_at_done = 1; first_busy = 0; first_stb = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        first_busy = which ? busy2 : busy1;
        first_stb  = which ? stb2  : stb1;
      end
      if (which ? busy2 : busy1) nbusy++;
      if (which ? done2 : done1) begin
        seen = 1;
        busy_at_done = which ? busy2 : busy1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int nb, base, tbase, act, bad;
    bit seen, bad_done, fb, fs;
    reset1 = 1'b1; led1 = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++; if (stb1 !== 1'b1)  begin tests_failed++; $display("[TB] FAIL reset_stb got %b want 1", stb1); end
    tests_run++; if (sclk1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_clk got %b want 1", sclk1); end
    tests_run++; if (dio1 !== 1'b1)  begin tests_failed++; $display("[TB] FAIL reset_dio got %b want 1", dio1); end
    tests_run++; if (busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy1); end
    tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done1); end
    base = cap0.size(); tbase = txl0.size();
    reset1 = 1'b0;
    wait_frame(0, 9000, nb, seen, bad_done, fb, fs);
    tests_run++; if (fb !== 1'b1 || fs !== 1'b0) begin tests_failed++; $display("[TB] FAIL start_cycle busy/stb got %b/%b want 1/0", fb, fs); end
    tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL first_frame_done got timeout want pulse"); end
    tests_run++; if (nb != 7900) begin tests_failed++; $display("[TB] FAIL frame_len got %0d want 7900", nb); end
    tests_run++; if (bad_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_at_done got %b want 0", bad_done); end
    tests_run++;
    if (txl0.size() != tbase + 3 || txl0[tbase] != 1 || txl0[tbase+1] != 17 || txl0[tbase+2] != 1) begin
      tests_failed++; $display("[TB] FAIL txn_lengths got %0d transactions want 1/17/1", txl0.size() - tbase);
    end
    bad = -1;
    for (int i = 0; i < 19; i++)
      if (cap0.size() <= base + i || cap0[base+i] !== exp_byte(i, 8'h00, 3'd7)) begin bad = i; break; end
    tests_run++; if (bad >= 0) begin tests_failed++; $display("[TB] FAIL zero_frame_bytes first bad index %0d want 19 matching bytes", bad); end
    act = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (!stb1 || busy1 || !sclk1 || !dio1) act++;
    end
    tests_run++; if (act != 0) begin tests_failed++; $display("[TB] FAIL idle_activity got %0d cycles want 0", act); end
  endtask

  task automatic test_pattern;
    logic [7:0] tbl[19] = '{8'h40, 8'hC0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h8F};
    int nb, base, bad;
    bit seen, bd, fb, fs;
    base = cap0.size();
    led1 = 8'b0000_0101;
    wait_frame(0, 9000, nb, seen, bd, fb, fs);
    tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL pattern_done got timeout want pulse"); end
    bad = -1;
    for (int i = 0; i < 19; i++)
      if (cap0.size() <= base + i || cap0[base+i] !== tbl[i]) begin bad = i; break; end
    tests_run++; if (bad >= 0) begin tests_failed++; $display("[TB] FAIL pattern05_bytes first bad index %0d got %h want %h", bad, (cap0.size() > base + bad) ? cap0[base+bad] : 8'hxx, tbl[bad]); end
    repeat (50) @(negedge clk);
    tests_run++; if (busy1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL no_retrigger busy got %b want 0", busy1); end
  endtask

  task automatic test_back_to_back;
    int nb, base, bad;
    bit seen, bd, fb, fs;
    base = cap0.size();
    led1 = 8'h01;
    repeat (3000) @(negedge clk);
    led1 = 8'h80;
    wait_frame(0, 9000, nb, seen, bd, fb, fs);
    tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL b2b_first_done got timeout want pulse"); end
    @(negedge clk);
    tests_run++; if (busy1 !== 1'b1 || stb1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_restart busy/stb got %b/%b want 1/0", busy1, stb1); end
    wait_frame(0, 9000, nb, seen, bd, fb, fs);
    tests_run++; if (!seen || nb != 7899) begin tests_failed++; $display("[TB] FAIL b2b_second_frame got busy %0d done %b want 7899 1", nb, seen); end
    bad = -1;
    for (int i = 0; i < 38; i++)
      if (cap0.size() <= base + i || cap0[base+i] !== exp_byte(i % 19, (i < 19) ? 8'h01 : 8'h80, 3'd7)) begin bad = i; break; end
    tests_run++; if (bad >= 0) begin tests_failed++; $display("[TB] FAIL b2b_bytes first bad index %0d want 38 matching bytes", bad); end
    tests_run++; if (cap0.size() < base + 37 || cap0[base+3] !== 8'h01 || cap0[base+36] !== 8'h01) begin
      tests_failed++; $display("[TB] FAIL b2b_led_bytes frame1 k1 / frame2 k15 wrong want 01/01");
    end
  endtask

  task automatic test_reset_midframe;
    int nb, base, bad, c;
    bit seen, bd, fb, fs;
    base = cap0.size();
    led1 = 8'h42;
    for (c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (cap0.size() >= base + 2 && nbits[0] >= 3) break;
    end
    tests_run++; if (c >= 4000) begin tests_failed++; $display("[TB] FAIL midframe_reach got timeout want T2 bit 3"); end
    #2 reset1 = 1'b1;
    #1;
    tests_run++; if (stb1 !== 1'b1 || sclk1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL async_reset stb/clk/busy/done got %b%b%b%b want 1100", stb1, sclk1, busy1, done1);
    end
    repeat (3) @(negedge clk);
    base = cap0.size();
    reset1 = 1'b0;
    wait_frame(0, 9000, nb, seen, bd, fb, fs);
    tests_run++; if (!seen || nb != 7900) begin tests_failed++; $display("[TB] FAIL restart_frame got busy %0d done %b want 7900 1", nb, seen); end
    bad = -1;
    for (int i = 0; i < 19; i++)
      if (cap0.size() <= base + i || cap0[base+i] !== exp_byte(i, 8'h42, 3'd7)) begin bad = i; break; end
    tests_run++; if (bad >= 0) begin tests_failed++; $display("[TB] FAIL restart_bytes first bad index %0d want 19 matching bytes", bad); end
  endtask

  task automatic test_fast_divider;
    int nb, base, serr;
    bit seen, bd, fb, fs;
    base = cap1.size(); serr = stab_err[1];
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
    wait_frame(1, 1000, nb, seen, bd, fb, fs);
    tests_run++; if (!seen || nb != 316) begin tests_failed++; $display("[TB] FAIL fast_len got busy %0d done %b want 316 1", nb, seen); end
    tests_run++; if (cap1.size() < base + 19 || cap1[base+18] !== 8'h8A) begin tests_failed++; $display("[TB] FAIL fast_t3 got %0d bytes want 19 ending 8A", cap1.size() - base); end
    tests_run++; if (cap1.size() < base + 8 || cap1[base+3] !== 8'h01 || cap1[base+5] !== 8'h00 || cap1[base+7] !== 8'h01) begin
      tests_failed++; $display("[TB] FAIL fast_grid k1/k3/k5 wrong want 01/00/01 for A5");
    end
    tests_run++; if (stab_err[1] != serr) begin tests_failed++; $display("[TB] FAIL dio_stable got %0d changes during clk high want 0", stab_err[1] - serr); end
  endtask

  initial begin
    test_fast_divider();
    test_reset();
    test_pattern();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
